pixel_frame_sink: RTL and testbench

- Receiving end of the ray marcher's rendered-pixel stream (hcount/vcount/color/valid/new_frame).
- Writes each pixel into a double-buffered frame store and serves a registered random-access read port to the display/VGA side.
- On each new-frame indication, swaps the write and display banks, so the display always shows the last complete frame.

---
 rtl/pixel_frame_sink.sv | 175 +++++++++++++++++
 tb/tb_pixel_frame_sink.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_sink.sv
// Double-buffered pixel store fed by the ray marcher; swaps banks on each new_frame rising edge. Optional PIXEL_SINK_CLEAR_EN zeroes each new write bank.
// Latency: pixel written 2 clocks after sampling; disp_color_out 2 clocks after disp_* request.
// Backpressure: none; every valid pixel is accepted, out-of-range ones are counted and dropped.
module pixel_frame_sink #(
  parameter int DISPLAY_WIDTH  = 320,
  parameter int DISPLAY_HEIGHT = 180,
  parameter int H_BITS         = 9,
  parameter int V_BITS         = 8,
  parameter int COLOR_BITS     = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [H_BITS-1:0]     hcount_in,
  input  logic [V_BITS-1:0]     vcount_in,
  input  logic [COLOR_BITS-1:0] color_in,
  input  logic                  valid_in,
  input  logic                  new_frame_in,
  input  logic [H_BITS-1:0]     disp_hcount_in,
  input  logic [V_BITS-1:0]     disp_vcount_in,
  output logic [COLOR_BITS-1:0] disp_color_out,
  output logic                  frame_swapped_out,
  output logic [15:0]           frame_count_out,
  output logic [31:0]           last_frame_pixels_out,
  output logic [15:0]           dropped_out
);

  localparam int NPIX = DISPLAY_WIDTH * DISPLAY_HEIGHT;
  localparam int AW   = $clog2(NPIX);

  logic                  write_bank;
  logic                  nf_q;
  logic                  swap;
  logic [31:0]           pix_cnt;

  logic                  wr_inr;
  logic [AW-1:0]         wr_addr;
  logic                  rd_inr;
  logic [AW-1:0]         rd_addr;

  logic                  s1_vld;
  logic                  s1_inr;
  logic                  s1_tag;
  logic [AW-1:0]         s1_addr;
  logic [COLOR_BITS-1:0] s1_color;
  logic                  pix_we;

  logic                  r1_inr;
  logic                  r1_bank;
  logic [AW-1:0]         r1_addr;

  logic                  mem_we;
  logic                  mem_bank;
  logic [AW-1:0]         mem_addr;
  logic [COLOR_BITS-1:0] mem_dat;
  logic [COLOR_BITS-1:0] mem0 [NPIX];
  logic [COLOR_BITS-1:0] mem1 [NPIX];

  assign swap    = new_frame_in && !nf_q;
  assign wr_inr  = (32'(hcount_in) < 32'(DISPLAY_WIDTH)) && (32'(vcount_in) < 32'(DISPLAY_HEIGHT));
  assign wr_addr = AW'(32'(vcount_in) * 32'(DISPLAY_WIDTH) + 32'(hcount_in));
  assign rd_inr  = (32'(disp_hcount_in) < 32'(DISPLAY_WIDTH)) && (32'(disp_vcount_in) < 32'(DISPLAY_HEIGHT));
  assign rd_addr = AW'(32'(disp_vcount_in) * 32'(DISPLAY_WIDTH) + 32'(disp_hcount_in));
  assign pix_we  = s1_vld && s1_inr;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      write_bank            <= 1'b0;
      nf_q                  <= 1'b0;
      pix_cnt               <= '0;
      s1_vld                <= 1'b0;
      s1_inr                <= 1'b0;
      s1_tag                <= 1'b0;
      s1_addr               <= '0;
      s1_color              <= '0;
      r1_inr                <= 1'b0;
      r1_bank               <= 1'b1;
      r1_addr               <= '0;
      frame_swapped_out     <= 1'b0;
      frame_count_out       <= '0;
      last_frame_pixels_out <= '0;
      dropped_out           <= '0;
    end else begin
      nf_q     <= new_frame_in;
      s1_vld   <= valid_in;
      s1_inr   <= wr_inr;
      s1_addr  <= wr_addr;
      s1_color <= color_in;
      // a pixel arriving with the edge already belongs to the new frame
      s1_tag   <= swap ? ~write_bank : write_bank;
      r1_inr   <= rd_inr;
      r1_addr  <= rd_addr;
      r1_bank  <= ~write_bank;
      frame_swapped_out <= swap;
      if (valid_in && !wr_inr && dropped_out != 16'hFFFF)
        dropped_out <= dropped_out + 16'd1;
      if (swap) begin
        write_bank            <= ~write_bank;
        frame_count_out       <= frame_count_out + 16'd1;
        last_frame_pixels_out <= pix_cnt;
        pix_cnt               <= 32'(valid_in && wr_inr);
      end else if (valid_in && wr_inr) begin
        pix_cnt <= pix_cnt + 32'd1;
      end
    end
  end

`ifdef PIXEL_SINK_CLEAR_EN
  typedef enum logic {CLR_IDLE, CLR_BUSY} clr_state_t;

  clr_state_t    clr_state, clr_state_nxt;
  logic [AW-1:0] clr_addr, clr_addr_nxt;
  logic          clr_pend;
  logic          clr_we;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clr_state <= CLR_IDLE;
      clr_addr  <= '0;
      clr_pend  <= 1'b1;
    end else begin
      clr_state <= clr_state_nxt;
      clr_addr  <= clr_addr_nxt;
      clr_pend  <= 1'b0;
    end
  end

  // no clear write on the swap edge itself: that bank is about to be displayed
  always_comb begin
    clr_state_nxt = clr_state;
    clr_addr_nxt  = clr_addr;
    clr_we        = 1'b0;
    if (swap || (clr_state == CLR_IDLE && clr_pend)) begin
      clr_state_nxt = CLR_BUSY;
      clr_addr_nxt  = '0;
    end else if (clr_state == CLR_BUSY && !pix_we) begin
      clr_we = 1'b1;
      if (clr_addr == AW'(NPIX - 1)) begin
        clr_state_nxt = CLR_IDLE;
        clr_addr_nxt  = '0;
      end else begin
        clr_addr_nxt = clr_addr + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    mem_we   = pix_we && !rst_in;
    mem_bank = s1_tag;
    mem_addr = s1_addr;
    mem_dat  = s1_color;
`ifdef PIXEL_SINK_CLEAR_EN
    if (clr_we && !rst_in) begin
      mem_we   = 1'b1;
      mem_bank = write_bank;
      mem_addr = clr_addr;
      mem_dat  = '0;
    end
`endif
  end

  always_ff @(posedge clk_in) begin
    if (mem_we) begin
      if (mem_bank) mem1[mem_addr] <= mem_dat;
      else          mem0[mem_addr] <= mem_dat;
    end
  end

  // read-first: a same-cycle write to this address is seen on the next read
  always_ff @(posedge clk_in) begin
    if (rst_in || !r1_inr) disp_color_out <= '0;
    else                   disp_color_out <= r1_bank ? mem1[r1_addr] : mem0[r1_addr];
  end

endmodule

// File: tb/tb_pixel_frame_sink.sv
module tb_pixel_frame_sink;

  localparam int W  = 5;
  localparam int H  = 3;
  localparam int HB = 4;
  localparam int VB = 3;
  localparam int CB = 8;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [HB-1:0] hcount_in;
  logic [VB-1:0] vcount_in;
  logic [CB-1:0] color_in;
  logic          valid_in;
  logic          new_frame_in;
  logic [HB-1:0] disp_hcount_in;
  logic [VB-1:0] disp_vcount_in;
  logic [CB-1:0] disp_color_out;
  logic          frame_swapped_out;
  logic [15:0]   frame_count_out;
  logic [31:0]   last_frame_pixels_out;
  logic [15:0]   dropped_out;

  int n_cmp = 0;
  int n_bad = 0;

  pixel_frame_sink #(
    .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H), .H_BITS(HB), .V_BITS(VB), .COLOR_BITS(CB)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in), .color_in(color_in),
    .valid_in(valid_in), .new_frame_in(new_frame_in),
    .disp_hcount_in(disp_hcount_in), .disp_vcount_in(disp_vcount_in),
    .disp_color_out(disp_color_out), .frame_swapped_out(frame_swapped_out),
    .frame_count_out(frame_count_out), .last_frame_pixels_out(last_frame_pixels_out),
    .dropped_out(dropped_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input logic [HB-1:0] h, input logic [VB-1:0] v, input logic [CB-1:0] c);
    hcount_in = h; vcount_in = v; color_in = c; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic pulse_nf();
    new_frame_in = 1'b1;
    tick();
    new_frame_in = 1'b0;
  endtask

  task automatic set_rd(input logic [HB-1:0] h, input logic [VB-1:0] v);
    disp_hcount_in = h; disp_vcount_in = v;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; valid_in = 1'b0; new_frame_in = 1'b0;
    hcount_in = '0; vcount_in = '0; color_in = '0;
    set_rd(4'd15, 3'd0);
    tick(); tick();
    n_cmp++; if (disp_color_out !== 8'd0) begin n_bad++; $display("FAIL rst_disp: got %0d want 0", disp_color_out); end
    n_cmp++; if (frame_swapped_out !== 1'b0) begin n_bad++; $display("FAIL rst_swapped: got %0d want 0", frame_swapped_out); end
    n_cmp++; if (frame_count_out !== 16'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", frame_count_out); end
    n_cmp++; if (last_frame_pixels_out !== 32'd0) begin n_bad++; $display("FAIL rst_last: got %0d want 0", last_frame_pixels_out); end
    n_cmp++; if (dropped_out !== 16'd0) begin n_bad++; $display("FAIL rst_dropped: got %0d want 0", dropped_out); end
    rst_in = 1'b0;
  endtask

  task automatic test_swap_write();
    pulse_nf();
    n_cmp++; if (frame_swapped_out !== 1'b1) begin n_bad++; $display("FAIL first_swap_pulse: got %0d want 1", frame_swapped_out); end
    n_cmp++; if (frame_count_out !== 16'd1) begin n_bad++; $display("FAIL first_swap_count: got %0d want 1", frame_count_out); end
    send(4'd4, 3'd2, 8'd7);
    n_cmp++; if (frame_swapped_out !== 1'b0) begin n_bad++; $display("FAIL pulse_width: got %0d want 0", frame_swapped_out); end
    tick(); tick();
    pulse_nf();
    n_cmp++; if (frame_count_out !== 16'd2) begin n_bad++; $display("FAIL second_swap_count: got %0d want 2", frame_count_out); end
    n_cmp++; if (last_frame_pixels_out !== 32'd1) begin n_bad++; $display("FAIL second_swap_last: got %0d want 1", last_frame_pixels_out); end
    set_rd(4'd4, 3'd2);
    tick();
    n_cmp++; if (disp_color_out !== 8'd0) begin n_bad++; $display("FAIL rd_latency_early: got %0d want 0", disp_color_out); end
    tick();
    n_cmp++; if (disp_color_out !== 8'd7) begin n_bad++; $display("FAIL rd_bank1_addr14: got %0d want 7", disp_color_out); end
    set_rd(4'd15, 3'd0);
  endtask

  task automatic test_held_high();
    int pulses;
    for (int a = 0; a < W * H; a++)
      send(HB'(a % W), VB'(a / W), CB'(16 + a));
    pulses = 0;
    new_frame_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) new_frame_in = 1'b0;
      tick();
      if (frame_swapped_out === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL held_high_pulses: got %0d want 1", pulses); end
    n_cmp++; if (last_frame_pixels_out !== 32'd15) begin n_bad++; $display("FAIL held_high_last: got %0d want 15", last_frame_pixels_out); end
    n_cmp++; if (frame_count_out !== 16'd3) begin n_bad++; $display("FAIL held_high_count: got %0d want 3", frame_count_out); end
    set_rd(4'd0, 3'd0);
    tick();
    set_rd(4'd4, 3'd2);
    tick();
    n_cmp++; if (disp_color_out !== 8'd16) begin n_bad++; $display("FAIL b2b_rd_addr0: got %0d want 16", disp_color_out); end
    tick();
    n_cmp++; if (disp_color_out !== 8'd30) begin n_bad++; $display("FAIL b2b_rd_addr14: got %0d want 30", disp_color_out); end
    set_rd(4'd15, 3'd0);
  endtask

  task automatic test_out_of_range();
    send(4'd0, 3'd1, 8'd55);
    send(4'd5, 3'd0, 8'd99);
    send(4'd0, 3'd3, 8'd99);
    n_cmp++; if (dropped_out !== 16'd2) begin n_bad++; $display("FAIL oor_dropped: got %0d want 2", dropped_out); end
    pulse_nf();
    n_cmp++; if (last_frame_pixels_out !== 32'd1) begin n_bad++; $display("FAIL oor_last: got %0d want 1", last_frame_pixels_out); end
    n_cmp++; if (frame_count_out !== 16'd4) begin n_bad++; $display("FAIL oor_count: got %0d want 4", frame_count_out); end
    set_rd(4'd0, 3'd1);
    tick();
    set_rd(4'd4, 3'd2);
    tick();
    n_cmp++; if (disp_color_out !== 8'd55) begin n_bad++; $display("FAIL oor_no_wrap_write: got %0d want 55", disp_color_out); end
    tick();
    n_cmp++; if (disp_color_out !== 8'd7) begin n_bad++; $display("FAIL oor_bank1_intact: got %0d want 7", disp_color_out); end
    set_rd(4'd15, 3'd0);
  endtask

  task automatic test_swap_boundary();
    send(4'd0, 3'd0, 8'hA1);
    hcount_in = 4'd1; vcount_in = 3'd0; color_in = 8'hB2; valid_in = 1'b1;
    new_frame_in = 1'b1;
    tick();
    valid_in = 1'b0; new_frame_in = 1'b0;
    n_cmp++; if (frame_swapped_out !== 1'b1) begin n_bad++; $display("FAIL bnd_pulse: got %0d want 1", frame_swapped_out); end
    n_cmp++; if (last_frame_pixels_out !== 32'd1) begin n_bad++; $display("FAIL bnd_last_excl: got %0d want 1", last_frame_pixels_out); end
    n_cmp++; if (frame_count_out !== 16'd5) begin n_bad++; $display("FAIL bnd_count: got %0d want 5", frame_count_out); end
    set_rd(4'd0, 3'd0);
    tick();
    set_rd(4'd1, 3'd0);
    tick();
    n_cmp++; if (disp_color_out !== 8'hA1) begin n_bad++; $display("FAIL bnd_early_pix_displayed: got %0h want a1", disp_color_out); end
    tick();
    n_cmp++; if (disp_color_out !== 8'd17) begin n_bad++; $display("FAIL bnd_edge_pix_not_old_bank: got %0d want 17", disp_color_out); end
    pulse_nf();
    n_cmp++; if (last_frame_pixels_out !== 32'd1) begin n_bad++; $display("FAIL bnd_last_incl: got %0d want 1", last_frame_pixels_out); end
    tick(); tick();
    n_cmp++; if (disp_color_out !== 8'hB2) begin n_bad++; $display("FAIL bnd_edge_pix_new_bank: got %0h want b2", disp_color_out); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    send(4'd2, 3'd0, 8'hCC);
    rst_in = 1'b1; new_frame_in = 1'b1;
    tick();
    n_cmp++; if (disp_color_out !== 8'd0) begin n_bad++; $display("FAIL mid_rst_disp: got %0d want 0", disp_color_out); end
    n_cmp++; if (frame_swapped_out !== 1'b0) begin n_bad++; $display("FAIL mid_rst_swapped: got %0d want 0", frame_swapped_out); end
    n_cmp++; if (frame_count_out !== 16'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d want 0", frame_count_out); end
    n_cmp++; if (last_frame_pixels_out !== 32'd0) begin n_bad++; $display("FAIL mid_rst_last: got %0d want 0", last_frame_pixels_out); end
    n_cmp++; if (dropped_out !== 16'd0) begin n_bad++; $display("FAIL mid_rst_dropped: got %0d want 0", dropped_out); end
    rst_in = 1'b0; new_frame_in = 1'b0;
    set_rd(4'd15, 3'd0);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (frame_swapped_out === 1'b1) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL mid_rst_no_pulse: got %0d want 0", pulses); end
    pulse_nf();
    n_cmp++; if (frame_count_out !== 16'd1) begin n_bad++; $display("FAIL post_rst_count: got %0d want 1", frame_count_out); end
    set_rd(4'd2, 3'd0);
    tick(); tick();
    n_cmp++; if (disp_color_out !== 8'd18) begin n_bad++; $display("FAIL inflight_write_discarded: got %0d want 18", disp_color_out); end
  endtask

  task automatic test_clear();
    logic [CB-1:0] exp_c;
    pulse_nf();
    for (int k = 0; k < 9; k++) tick();
    send(4'd1, 3'd1, 8'd9);
    for (int k = 0; k < 25; k++) tick();
    pulse_nf();
    for (int a = 0; a < W * H; a++) begin
      set_rd(HB'(a % W), VB'(a / W));
      tick(); tick();
      exp_c = (a == 6) ? 8'd9 : 8'd0;
      n_cmp++; if (disp_color_out !== exp_c) begin n_bad++; $display("FAIL clear_addr%0d: got %0d want %0d", a, disp_color_out, exp_c); end
    end
  endtask

  initial begin
    test_reset();
`ifdef PIXEL_SINK_CLEAR_EN
    test_clear();
`else
    test_swap_write();
    test_held_high();
    test_out_of_range();
    test_swap_boundary();
    test_reset_mid();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
